// File: rtl/puf_response_voter_if.sv
// -----------------------------------------------------------------------------
// puf_response_voter_if
//
// Result channel of the PUF response voter: the voted response, the per-bit
// instability flags and the timeout error, qualified by resp_valid and
// acknowledged by resp_ready.
//
//   resp        voted response (WIDTH bits)
//   unstable    per-bit flag, 1 = bit differed across the evaluations
//   err         measurement aborted by timeout
//   resp_valid  resp/unstable/err are valid
//   resp_ready  consumer accepts the result
//
// Modports:
//   master  the voter (drives the result, receives resp_ready)
//   slave   the consumer of the result
// -----------------------------------------------------------------------------
interface puf_response_voter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] resp;
   logic [WIDTH-1:0] unstable;
   logic             err;
   logic             resp_valid;
   logic             resp_ready;

   modport master (
      output resp,
      output unstable,
      output err,
      output resp_valid,
      input  resp_ready
   );

   modport slave (
      input  resp,
      input  unstable,
      input  err,
      input  resp_valid,
      output resp_ready
   );
endinterface

// File: rtl/puf_response_voter.sv
// -----------------------------------------------------------------------------
// puf_response_voter
//
// Evaluates a PUF core N = 2^NREP_LOG2 times per measurement and produces a
// per-bit majority vote of the raw responses together with a per-bit
// instability flag. Each evaluation is a one-cycle puf_eval strobe followed by
// a wait for puf_done; if puf_done does not arrive within TMO cycles the
// measurement is aborted and reported with err=1.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   start_i      request a measurement (sampled only in IDLE)
//   puf_eval_o   one-cycle evaluate strobe to the PUF core
//   puf_done_i   PUF raw response valid this cycle
//   puf_resp_i   raw PUF response, qualified by puf_done_i
//   busy_o       high in every state except IDLE
//   res_if       result channel (resp, unstable, err, resp_valid, resp_ready)
// -----------------------------------------------------------------------------
module puf_response_voter #(
   parameter int WIDTH     = 8,
   parameter int NREP_LOG2 = 3,
   parameter int TMO       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic                  puf_eval_o,
   input  logic                  puf_done_i,
   input  logic [WIDTH-1:0]      puf_resp_i,
   output logic                  busy_o,
   puf_response_voter_if.master  res_if
);

   localparam int N  = 1 << NREP_LOG2;
   // A per-bit counter must hold the value N itself, hence one extra bit.
   localparam int CW = NREP_LOG2 + 1;
   localparam int WW = $clog2(TMO + 1);

   localparam logic [CW-1:0]        HALF     = CW'(N / 2);
   localparam logic [CW-1:0]        FULL     = CW'(N);
   localparam logic [NREP_LOG2-1:0] REP_LAST = '1;
   localparam logic [WW-1:0]        TMO_LAST = WW'(TMO - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [NREP_LOG2-1:0]        rep_q, rep_d;
   logic [WIDTH-1:0][CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0][CW-1:0]    cnt_acc;
   logic [WW-1:0]               wcnt_q, wcnt_d;
   logic [WIDTH-1:0]            resp_q, resp_d;
   logic [WIDTH-1:0]            unst_q, unst_d;
   logic                        err_q, err_d;

   // Strict majority: a tie (count == N/2) resolves to 0.
   function automatic logic vote_bit(input logic [CW-1:0] c);
      return c > HALF;
   endfunction

   // A bit is stable only if it was 0 in every evaluation or 1 in every one.
   function automatic logic unstable_bit(input logic [CW-1:0] c);
      return (c != '0) && (c != FULL);
   endfunction

   always_comb begin
      state_d = state_q;
      rep_d   = rep_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      resp_d  = resp_q;
      unst_d  = unst_q;
      err_d   = err_q;

      // Counts including the response presented this cycle; the final vote is
      // taken from these so the last evaluation does not need an extra cycle.
      for (int i = 0; i < WIDTH; i++) begin
         cnt_acc[i] = cnt_q[i] + CW'(puf_resp_i[i]);
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = EVAL;
               rep_d   = '0;
               cnt_d   = '0;
               wcnt_d  = '0;
            end
         end

         EVAL: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (puf_done_i) begin
               cnt_d  = cnt_acc;
               rep_d  = rep_q + NREP_LOG2'(1);
               wcnt_d = '0;
               if (rep_q == REP_LAST) begin
                  state_d = DONE;
                  err_d   = 1'b0;
                  for (int i = 0; i < WIDTH; i++) begin
                     resp_d[i] = vote_bit(cnt_acc[i]);
                     unst_d[i] = unstable_bit(cnt_acc[i]);
                  end
               end else begin
                  state_d = EVAL;
               end
            end else if (wcnt_q == TMO_LAST) begin
               // TMO-th consecutive cycle without puf_done: abort.
               state_d = DONE;
               wcnt_d  = '0;
               resp_d  = '0;
               unst_d  = '1;
               err_d   = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end

         DONE: begin
            if (res_if.resp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rep_q   <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         resp_q  <= '0;
         unst_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rep_q   <= rep_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         resp_q  <= resp_d;
         unst_q  <= unst_d;
         err_q   <= err_d;
      end
   end

   assign puf_eval_o        = (state_q == EVAL);
   assign busy_o            = (state_q != IDLE);
   assign res_if.resp_valid = (state_q == DONE);
   assign res_if.resp       = resp_q;
   assign res_if.unstable   = unst_q;
   assign res_if.err        = err_q;

endmodule

// File: tb/tb_puf_response_voter.sv
module tb_puf_response_voter;

   localparam int WIDTH     = 8;
   localparam int NREP_LOG2 = 3;
   localparam int N         = 8;
   localparam int TMO       = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_m = 1'b0;
   logic       start_hs = 1'b0;
   logic       start;
   logic       puf_eval;
   logic       puf_done = 1'b0;
   logic [7:0] puf_resp = 8'h00;
   logic       busy;

   assign start = start_m | start_hs;

   puf_response_voter_if #(.WIDTH(WIDTH)) rif ();

   puf_response_voter #(
      .WIDTH    (WIDTH),
      .NREP_LOG2(NREP_LOG2),
      .TMO      (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .puf_eval_o(puf_eval),
      .puf_done_i(puf_done),
      .puf_resp_i(puf_resp),
      .busy_o    (busy),
      .res_if    (rif.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int eval_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (puf_eval) eval_cnt <= eval_cnt + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] resp;
      logic [7:0] unst;
      logic       err;
      int         lat;
      int         hold;
      bit         hs_start;
   } exp_t;

   exp_t exp_q[$];
   int   start_cyc = 0;

   // measurement plan consumed by the reference model and the stimulus
   logic [7:0] m_vals[8];
   int         m_dly[8];
   int         m_tmo_rep = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic note(input string nm);
      total++;
      bad++;
      $display("FAIL %s: cycle bound expired (t=%0t)", nm, $time);
   endtask

   // Reference model: count ones per bit across the evaluations, strict
   // majority vote, instability = not all-equal; latency from the cycle
   // timing (1 EVAL + (d+1) WAIT per rep, plus the start cycle).
   function automatic exp_t model();
      exp_t e;
      int   c;
      e.lat = 1;
      if (m_tmo_rep < 0) begin
         for (int b = 0; b < 8; b++) begin
            c = 0;
            for (int r = 0; r < N; r++) c += int'(m_vals[r][b]);
            e.resp[b] = (c > N / 2);
            e.unst[b] = (c != 0) && (c != N);
         end
         e.err = 1'b0;
         for (int r = 0; r < N; r++) e.lat += m_dly[r] + 2;
      end else begin
         e.resp = 8'h00;
         e.unst = 8'hFF;
         e.err  = 1'b1;
         for (int r = 0; r < m_tmo_rep; r++) e.lat += m_dly[r] + 2;
         e.lat += 1 + TMO;
      end
      e.hold     = 0;
      e.hs_start = 1'b0;
      return e;
   endfunction

   task automatic wait_eval(output bit ok);
      int n = 0;
      while (!puf_eval && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = puf_eval;
   endtask

   task automatic run_meas(input int hold, input bit hs_start, input bit wait_start);
      exp_t e;
      int   ev0;
      int   n;
      bit   ok;
      e = model();
      e.hold     = hold;
      e.hs_start = hs_start;
      exp_q.push_back(e);
      ev0 = eval_cnt;
      @(negedge clk);
      start_m   = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start_m = 1'b0;
      for (int r = 0; r < N; r++) begin
         wait_eval(ok);
         if (!ok) begin
            note("eval_wait");
            break;
         end
         // garbage during EVAL must be ignored
         puf_done = 1'($urandom_range(0, 1));
         puf_resp = 8'($urandom);
         @(negedge clk);
         puf_done = 1'b0;
         if (r == m_tmo_rep) begin
            if (wait_start) start_m = 1'b1;
            @(negedge clk);
            start_m = 1'b0;
            break;
         end
         repeat (m_dly[r]) @(negedge clk);
         puf_done = 1'b1;
         puf_resp = m_vals[r];
         if (wait_start && r == 2) start_m = 1'b1;
         @(negedge clk);
         puf_done = 1'b0;
         start_m  = 1'b0;
      end
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || busy) note("drain");
      chk("eval_count", eval_cnt - ev0, (m_tmo_rep >= 0) ? m_tmo_rep + 1 : N);
   endtask

   task automatic plan_clear();
      for (int r = 0; r < N; r++) begin
         m_vals[r] = 8'h00;
         m_dly[r]  = 0;
      end
      m_tmo_rep = -1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_puf_eval"}, puf_eval, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, rif.resp_valid, 0);
      chk({tag, "_resp"}, rif.resp, 0);
      chk({tag, "_unstable"}, rif.unstable, 0);
      chk({tag, "_err"}, rif.err, 0);
   endtask

   // monitor: pops and compares whenever the DUT presents a result
   initial begin
      exp_t me;
      rif.resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && rif.resp_valid) begin
            if (exp_q.size() == 0) begin
               note("unexpected_result");
               rif.resp_ready = 1'b1;
               @(negedge clk);
               rif.resp_ready = 1'b0;
            end else begin
               me = exp_q.pop_front();
               chk("resp", rif.resp, me.resp);
               chk("unstable", rif.unstable, me.unst);
               chk("err", rif.err, me.err);
               chk("latency", cyc - start_cyc, me.lat);
               for (int h = 0; h < me.hold; h++) begin
                  @(negedge clk);
                  chk("hold_valid", rif.resp_valid, 1);
                  chk("hold_resp", rif.resp, me.resp);
                  chk("hold_unstable", rif.unstable, me.unst);
                  chk("hold_err", rif.err, me.err);
               end
               rif.resp_ready = 1'b1;
               start_hs       = me.hs_start;
               @(negedge clk);
               rif.resp_ready = 1'b0;
               start_hs       = 1'b0;
               chk("valid_after_hs", rif.resp_valid, 0);
               chk("busy_after_hs", busy, 0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      // reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_rst");

      // constant response on every rep, minimum latency
      plan_clear();
      for (int r = 0; r < N; r++) m_vals[r] = 8'hA5;
      run_meas(0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("idle_retain_resp", rif.resp, 8'hA5);
      chk("idle_retain_unst", rif.unstable, 8'h00);
      chk("idle_busy", busy, 0);

      // bit0 in 5 of 8, bit1 in 4 of 8 (tie), long consumer stall
      plan_clear();
      m_vals = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};
      run_meas(10, 1'b0, 1'b0);

      // puf_done never comes; start pulsed in WAIT and in handshake
      plan_clear();
      m_tmo_rep = 0;
      run_meas(2, 1'b1, 1'b1);

      // done in the last allowed WAIT cycle is still accepted
      plan_clear();
      for (int r = 0; r < N; r++) m_vals[r] = 8'($urandom);
      m_dly[3] = TMO - 1;
      run_meas(1, 1'b0, 1'b0);

      // timeout in a later rep, leaves err=1 / unstable=FF behind
      plan_clear();
      for (int r = 0; r < N; r++) begin
         m_vals[r] = 8'($urandom);
         m_dly[r]  = $urandom_range(0, 3);
      end
      m_tmo_rep = 5;
      run_meas(0, 1'b0, 1'b0);

      // reset during WAIT of rep 3
      @(negedge clk);
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      for (int r = 0; r < 4; r++) begin
         wait_eval(ok);
         if (!ok) note("rst_eval_wait");
         @(negedge clk);
         if (r < 3) begin
            puf_done = 1'b1;
            puf_resp = 8'($urandom);
            @(negedge clk);
            puf_done = 1'b0;
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      chk("no_eval_after_rst", puf_eval, 0);
      chk("idle_after_rst", busy, 0);

      // fresh full measurement after reset
      plan_clear();
      for (int r = 0; r < N; r++) m_vals[r] = 8'($urandom);
      run_meas(0, 1'b1, 1'b1);

      // randomized measurements
      for (int k = 0; k < 25; k++) begin
         logic [7:0] base;
         plan_clear();
         base = 8'($urandom);
         for (int r = 0; r < N; r++) begin
            m_vals[r] = base ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            m_dly[r]  = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 4);
         end
         if ($urandom_range(0, 5) == 0) m_tmo_rep = $urandom_range(0, N - 1);
         run_meas($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/puf_response_voter.md
PUF_RESPONSE_VOTER -- requirements
Module: puf_response_voter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: PUF response width in bits.
REQ-002 SHALL have parameter NREP_LOG2, default 3: evaluations per measurement, N = 2^NREP_LOG2.
REQ-003 SHALL have parameter TMO, default 16: maximum WAIT cycles allowed per evaluation.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  request a measurement; sampled only in IDLE.
REQ-007 puf_eval  output  1  one-cycle evaluate strobe to the PUF core.
REQ-008 puf_done  input  1  PUF core raw response valid this cycle.
REQ-009 puf_resp  input  WIDTH  raw PUF response, qualified by puf_done.
REQ-010 resp  output  WIDTH  majority-voted response.
REQ-011 unstable  output  WIDTH  per-bit flag, 1 = bit differed across the N evaluations.
REQ-012 err  output  1  measurement aborted by timeout.
REQ-013 resp_valid  output  1  resp/unstable/err valid.
REQ-014 resp_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, EVAL, WAIT, DONE.
REQ-017 IDLE: start=1 -> EVAL next cycle; rep counter, per-bit counters and WAIT counter cleared.
REQ-018 EVAL: puf_eval=1 for exactly this one cycle; -> WAIT unconditionally.
REQ-019 WAIT: puf_done=1 -> each per-bit counter (width NREP_LOG2+1) increments where puf_resp bit=1; rep counter increments.
REQ-020 WAIT with puf_done=1: -> DONE if this was rep N-1, else -> EVAL; WAIT counter cleared.
REQ-021 WAIT with puf_done=0: WAIT counter increments; on the TMO-th consecutive such cycle -> DONE with err=1.
REQ-022 On normal entry to DONE, registered outputs: resp[i] = (count[i] > N/2); ties give 0; unstable[i] = (count[i] != 0 && count[i] != N); err=0.
REQ-023 On timeout entry to DONE, registered outputs: resp = 0, unstable = all ones, err = 1.
REQ-024 DONE: resp_valid=1; resp/unstable/err held stable until handshake.
REQ-025 DONE with resp_ready=1 -> IDLE next cycle; resp_valid=0 from that cycle.
REQ-026 resp/unstable/err SHALL retain their last values in IDLE until the next DONE entry.
REQ-027 puf_done SHALL be ignored in IDLE, EVAL and DONE.
REQ-028 start SHALL be ignored when busy=1, including the handshake cycle.
REQ-029 Minimum latency: start sampled in cycle 0, puf_done in the first WAIT cycle for every rep -> resp_valid=1 in cycle 2N+1.
REQ-030 Per-bit counter SHALL NOT wrap: maximum value N fits NREP_LOG2+1 bits.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and clear all counters, from any state including mid-measurement.
REQ-032 Output values after reset: puf_eval=0, resp=0, unstable=0, err=0, resp_valid=0, busy=0.
REQ-033 No puf_eval pulse SHALL be issued in the cycle after rst is released unless start was sampled in IDLE.

Verification (WIDTH=8, N=8, TMO=16)
REQ-034 puf_resp=0xA5 on all 8 reps, puf_done one cycle after each puf_eval -> resp=0xA5, unstable=0x00, err=0, resp_valid rises in cycle 17 after start.
REQ-035 bit0=1 in 5 of 8 reps, bit1=1 in 4 of 8, other bits constant 0 -> resp=0x01, unstable=0x03.
REQ-036 puf_done never asserted -> one puf_eval pulse only; DONE after 16 WAIT cycles with err=1, resp=0x00, unstable=0xFF.
REQ-037 resp_ready held low 10 cycles in DONE -> resp_valid stays 1 and outputs unchanged; resp_ready=1 -> IDLE next cycle, busy=0.
REQ-038 rst=1 during WAIT of rep 3 -> next cycle IDLE, all outputs at reset values; fresh start gives a full 8-rep measurement.
REQ-039 start pulsed during WAIT and in the handshake cycle -> no extra measurement; puf_eval count equals 8 per accepted start.
